mem_bist_ctrl: RTL and testbench

MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

---
 rtl/mem_bist_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist_ctrl.sv
// March-style memory BIST sequencer: writes a pattern and its complement, reads each back
// through a one-cycle registered memory, and reports a saturating error count and the first failing address.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | waiting for start after reset
// W0     | write P(a) to addresses 0..DEPTH-1
// R0     | read addresses 0..DEPTH-1, compare one cycle later
// C0     | drain compare of the last R0 read
// W1     | write ~P(a) to addresses 0..DEPTH-1
// R1     | read addresses 0..DEPTH-1, compare one cycle later
// C1     | drain compare of the last R1 read
// DONE   | result held until next start
module mem_bist_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int ADDR  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic             fail_valid,
    output logic [ADDR-1:0]  fail_addr,
    output logic             write_en,
    output logic [ADDR-1:0]  write_addr,
    output logic [WIDTH-1:0] write_data,
    output logic [ADDR-1:0]  read_addr,
    input  logic [WIDTH-1:0] read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W0,
        S_R0,
        S_C0,
        S_W1,
        S_R1,
        S_C1,
        S_DONE
    } state_t;

    localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);

    function automatic logic [WIDTH-1:0] pattern(input logic [ADDR-1:0] a, input logic inv);
        logic [31:0] prod;
        prod = 32'(a) * 32'h11;
        return inv ? ~WIDTH'(prod) : WIDTH'(prod);
    endfunction

    state_t           state;
    logic             cmp_valid;
    logic [ADDR-1:0]  cmp_addr;
    logic [WIDTH-1:0] cmp_exp;
    logic             mismatch;
    logic [7:0]       err_next;

    // read_data answers the address issued last cycle, so it is checked against the registered expectation
    always_comb begin
        mismatch = 1'b0;
        err_next = err_count;
        if (cmp_valid && (read_data != cmp_exp)) begin
            mismatch = 1'b1;
            if (err_count != 8'hFF) begin
                err_next = err_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 8'd0;
            fail_valid <= 1'b0;
            fail_addr  <= '0;
            write_en   <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            read_addr  <= '0;
            cmp_valid  <= 1'b0;
            cmp_addr   <= '0;
            cmp_exp    <= '0;
        end else begin
            cmp_valid <= 1'b0;
            err_count <= err_next;
            if (mismatch && !fail_valid) begin
                fail_valid <= 1'b1;
                fail_addr  <= cmp_addr;
            end

            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_W0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= 8'd0;
                        fail_valid <= 1'b0;
                        fail_addr  <= '0;
                        write_en   <= 1'b1;
                        write_addr <= '0;
                        write_data <= pattern('0, 1'b0);
                        read_addr  <= '0;
                    end
                end

                S_W0, S_W1: begin
                    if (write_addr == LAST_ADDR) begin
                        state      <= (state == S_W0) ? S_R0 : S_R1;
                        write_en   <= 1'b0;
                        write_addr <= '0;
                        write_data <= '0;
                        read_addr  <= '0;
                    end else begin
                        write_addr <= write_addr + 1'b1;
                        write_data <= pattern(write_addr + 1'b1, state == S_W1);
                    end
                end

                S_R0, S_R1: begin
                    cmp_valid <= 1'b1;
                    cmp_addr  <= read_addr;
                    cmp_exp   <= pattern(read_addr, state == S_R1);
                    if (read_addr == LAST_ADDR) begin
                        state     <= (state == S_R0) ? S_C0 : S_C1;
                        read_addr <= '0;
                    end else begin
                        read_addr <= read_addr + 1'b1;
                    end
                end

                S_C0: begin
                    state      <= S_W1;
                    write_en   <= 1'b1;
                    write_addr <= '0;
                    write_data <= pattern('0, 1'b1);
                end

                S_C1: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_next == 8'd0);
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: a faultable 8x8 registered-read memory, directed and randomized runs,
// cycle-by-cycle schedule checks and end-of-run results predicted from the fault description.
module tb_mem_bist_ctrl;

    localparam int D = 8;
    localparam int W = 8;
    localparam int A = 3;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         busy;
    logic         done;
    logic         pass;
    logic [7:0]   err_count;
    logic         fail_valid;
    logic [A-1:0] fail_addr;
    logic         write_en;
    logic [A-1:0] write_addr;
    logic [W-1:0] write_data;
    logic [A-1:0] read_addr;
    logic [W-1:0] read_data;

    int checks = 0;
    int errors = 0;

    // fault description: 0 none, 1 bit fault_bit of fault_addr stuck at 0, 2 fault_addr reads fault_val
    int       fault_kind = 0;
    int       fault_addr = 0;
    int       fault_bit  = 0;
    logic [7:0] fault_val = 8'h00;

    logic [7:0] mem [0:D-1];

    mem_bist_ctrl #(.WIDTH(W), .DEPTH(D), .ADDR(A)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_valid (fail_valid),
        .fail_addr  (fail_addr),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr  (read_addr),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] faulty(input int a, input logic [7:0] stored);
        if (fault_kind == 1 && a == fault_addr) return stored & ~(8'd1 << fault_bit);
        if (fault_kind == 2 && a == fault_addr) return fault_val;
        return stored;
    endfunction

    always @(posedge clk) begin
        if (write_en) mem[write_addr] <= write_data;
        read_data <= faulty(int'(read_addr), mem[read_addr]);
    end

    function automatic logic [7:0] ref_pat(input int a, input int p);
        logic [7:0] v;
        v = 8'((a * 17) % 256);
        return (p != 0) ? ~v : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compute_expect(output int e_err, output int e_first);
        e_err   = 0;
        e_first = -1;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < D; a++) begin
                if (faulty(a, ref_pat(a, p)) !== ref_pat(a, p)) begin
                    if (e_first < 0) e_first = a;
                    if (e_err < 255) e_err++;
                end
            end
        end
    endtask

    // cycle k counts from the start edge; pulse_at/abort_at of -1 disables them
    task automatic run_bist(input int pulse_at, input int abort_at);
        int e_err, e_first;
        int ra, wa, wp;
        logic exp_we, exp_rd;
        compute_expect(e_err, e_first);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 4 * D + 2; k++) begin
            @(negedge clk);
            start = (k == pulse_at);
            exp_we = 1'b0; exp_rd = 1'b0; wa = 0; ra = 0; wp = 0;
            if (k < D) begin
                exp_we = 1'b1; wa = k; wp = 0;
            end else if (k < 2 * D) begin
                exp_rd = 1'b1; ra = k - D;
            end else if (k == 2 * D) begin
                exp_we = 1'b0;
            end else if (k < 3 * D + 1) begin
                exp_we = 1'b1; wa = k - 2 * D - 1; wp = 1;
            end else if (k < 4 * D + 1) begin
                exp_rd = 1'b1; ra = k - 3 * D - 1;
            end
            if (k == 0) begin
                chk("start_clr_err", err_count, 0);
                chk("start_clr_fv", fail_valid, 0);
                chk("start_clr_fa", fail_addr, 0);
            end
            chk("run_busy", busy, 1);
            chk("run_done_low", done, 0);
            chk("run_we", write_en, exp_we);
            if (exp_we) begin
                chk("run_waddr", write_addr, wa);
                chk("run_wdata", write_data, ref_pat(wa, wp));
            end
            if (exp_rd) chk("run_raddr", read_addr, ra);
            if (k == abort_at) begin
                rst_n = 1'b0;
                start = 1'b0;
                #1;
                chk("abort_we", write_en, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_err", err_count, 0);
                return;
            end
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_we", write_en, 0);
        chk("end_pass", pass, (e_err == 0));
        chk("end_err", err_count, e_err);
        chk("end_fv", fail_valid, (e_first >= 0));
        chk("end_fa", fail_addr, (e_first >= 0) ? e_first : 0);
    endtask

    task automatic idle_check(input int n, input logic exp_done);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_we", write_en, 0);
            chk("idle_done", done, exp_done);
        end
    endtask

    initial begin
        int pulse;
        for (int i = 0; i < D; i++) mem[i] = 8'h00;
        rst_n = 1'b0;
        start = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_fv", fail_valid, 0);
        chk("rst_fa", fail_addr, 0);
        chk("rst_we", write_en, 0);
        chk("rst_wa", write_addr, 0);
        chk("rst_wd", write_data, 0);
        chk("rst_ra", read_addr, 0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        idle_check(3, 1'b0);

        // fault-free run, result held afterwards
        fault_kind = 0;
        run_bist(-1, -1);
        idle_check(3, 1'b1);
        chk("held_pass", pass, 1);

        // bit0 of address 5 stuck at 0
        fault_kind = 1; fault_addr = 5; fault_bit = 0;
        run_bist(-1, -1);

        // address 2 stuck at FF
        fault_kind = 2; fault_addr = 2; fault_val = 8'hFF;
        run_bist(-1, -1);

        // restart from DONE, start pulsed during R0 is ignored
        fault_kind = 0;
        run_bist(10, -1);

        // reset during W1
        fault_kind = 1; fault_addr = 3; fault_bit = 4;
        run_bist(-1, 20);
        @(negedge clk);
        rst_n = 1'b1;
        idle_check(4, 1'b0);
        chk("post_abort_err", err_count, 0);
        chk("post_abort_fv", fail_valid, 0);

        for (int r = 0; r < 12; r++) begin
            fault_kind = $urandom_range(0, 2);
            fault_addr = $urandom_range(0, D - 1);
            fault_bit  = $urandom_range(0, W - 1);
            fault_val  = 8'($urandom_range(0, 255));
            pulse = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 32)) : -1;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_bist(pulse, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
